// File: rtl/ds_pkg.sv
// Shared FSM state type, mode encodings and accumulator sizing for image_downsampler.
package ds_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ds_state_t;

  localparam logic MODE_DECIMATE = 1'b0;
  localparam logic MODE_AVERAGE  = 1'b1;

  // Floor log2; FACTOR is a power of two so this is exact for it.
  function automatic int log2i(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= v) r = i;
    end
    return r;
  endfunction

  // Wide enough to hold FACTOR*FACTOR full-scale samples without overflow.
  function automatic int acc_w(input int pix_w, input int factor);
    return pix_w + 2 * log2i(factor);
  endfunction

endpackage

// File: rtl/ds_line_acc.sv
// Per-block-column accumulator line: one write port, one combinational read port, indexed by bx.
// No reset: the first line of each block row overwrites every entry before it is read.
module ds_line_acc #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 10,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/image_downsampler.sv
// Streaming FACTOR x FACTOR decimate/box-average downsampler; output registered 1 cycle after the block-completing input.
// Input stalls (in_ready low) whenever the output register is full and not being consumed; DS_ROUND_EN selects round-half-up averaging.
module image_downsampler
  import ds_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int FACTOR   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [CHANNELS*PIX_W-1:0] out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int LF    = log2i(FACTOR);
  localparam int SH    = 2 * LF;
  localparam int ACC_W = acc_w(PIX_W, FACTOR);
  localparam int NBX   = IMG_W / FACTOR;
  localparam int BX_W  = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [LF-1:0] SUB_LAST = LF'(FACTOR - 1);
`ifdef DS_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SH - 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  ds_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;

  logic [LF-1:0]               sub_col, sub_row;
  logic [BX_W-1:0]             bx;
  logic                        accept, first, emit, wr_en;
  logic [CHANNELS*ACC_W-1:0]   rd_data, wr_data;
  logic [CHANNELS*PIX_W-1:0]   out_next;
  logic [ACC_W-1:0]            pix_ext, prev_acc, sum_acc;

  assign sub_col  = col[LF-1:0];
  assign sub_row  = row[LF-1:0];
  assign bx       = BX_W'(col >> LF);
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign first    = (sub_col == '0) && (sub_row == '0);
  assign emit     = accept && (sub_col == SUB_LAST) && (sub_row == SUB_LAST);
  assign wr_en    = accept && ((mode_q == MODE_AVERAGE) || first);

  ds_line_acc #(
    .DEPTH (NBX),
    .WIDTH (CHANNELS * ACC_W),
    .IDX_W (BX_W)
  ) u_line_acc (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (bx),
    .wr_data (wr_data),
    .rd_idx  (bx),
    .rd_data (rd_data)
  );

  // Averaging accumulates every pixel of the block straight into entry bx;
  // decimation keeps only the top-left pixel there until the block closes.
  always_comb begin
    wr_data  = '0;
    out_next = '0;
    pix_ext  = '0;
    prev_acc = '0;
    sum_acc  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pix_ext  = ACC_W'(in_data[c*PIX_W +: PIX_W]);
      prev_acc = rd_data[c*ACC_W +: ACC_W];
      sum_acc  = first ? pix_ext : prev_acc + pix_ext;
      if (mode_q == MODE_AVERAGE) begin
        wr_data[c*ACC_W +: ACC_W]  = sum_acc;
        out_next[c*PIX_W +: PIX_W] = PIX_W'((sum_acc + RND) >> SH);
      end else begin
        wr_data[c*ACC_W +: ACC_W]  = pix_ext;
        out_next[c*PIX_W +: PIX_W] = prev_acc[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      mode_q    <= MODE_DECIMATE;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A new block result may replace the one being consumed on the same edge.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= out_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            mode_q <= mode;
            busy   <= 1'b1;
            col    <= '0;
            row    <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= FLUSH;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        FLUSH: begin
          if (!out_valid || out_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_downsampler.sv
// Self-checking bench: randomized frames against a block-arithmetic reference, plus directed backpressure/reset cases.
module tb_image_downsampler;

  localparam int PIX_W    = 8;
  localparam int CHANNELS = 1;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int FACTOR   = 2;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int NOUT     = (IMG_W / FACTOR) * (IMG_H / FACTOR);
`ifdef DS_ROUND_EN
  localparam int RND = FACTOR * FACTOR / 2;
`else
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic [CHANNELS*PIX_W-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic [CHANNELS*PIX_W-1:0] out_data;
  logic out_ready = 1'b1;
  logic busy;
  logic done;

  int checks = 0;
  int failures = 0;
  int pix [NPIX];
  int exp_q [$];
  int obs_q [$];

  image_downsampler #(
    .PIX_W (PIX_W), .CHANNELS (CHANNELS), .IMG_W (IMG_W), .IMG_H (IMG_H), .FACTOR (FACTOR)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .mode (mode),
    .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
    .out_valid (out_valid), .out_data (out_data), .out_ready (out_ready),
    .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: each output is a block sum / FACTOR^2 (or the block's top-left pixel).
  task automatic build_exp(input logic m);
    int sum;
    exp_q.delete();
    for (int by = 0; by < IMG_H / FACTOR; by++) begin
      for (int bx = 0; bx < IMG_W / FACTOR; bx++) begin
        sum = 0;
        for (int dy = 0; dy < FACTOR; dy++)
          for (int dx = 0; dx < FACTOR; dx++)
            sum += pix[(by*FACTOR + dy)*IMG_W + bx*FACTOR + dx];
        if (m) exp_q.push_back((sum + RND) / (FACTOR * FACTOR));
        else   exp_q.push_back(pix[by*FACTOR*IMG_W + bx*FACTOR]);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
  endtask

  // policy: 0 = full rate, 1 = random valid/ready, 2 = hold out_ready low 10 cycles at first output
  task automatic run_frame(input logic m, input int policy, input int abort_after, input bit glitch);
    int idx, nout, cyc, stall, prev_data;
    bit seen_done, prev_hold;
    idx = 0; nout = 0; cyc = 0; stall = 0; prev_data = 0;
    seen_done = 0; prev_hold = 0;
    build_exp(m);
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("busy_rise", busy, 1);
    while (!seen_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 3);
      mode = ~m;
      in_valid = (idx < NPIX) && ((policy != 1) || ($urandom_range(0, 3) != 0));
      in_data = PIX_W'(pix[(idx < NPIX) ? idx : 0]);
      if (policy == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if (policy == 2 && out_valid && nout == 0 && stall < 10) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      #1;
      if (prev_hold) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
      if (policy == 2 && out_valid && !out_ready) check_val("stall_data", out_data, exp_q[0]);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        seen_done = 1;
        check_val("done_after_all", nout, NOUT);
      end
      if (out_valid && out_ready) begin
        check_val("out_count_le", int'(nout < NOUT), 1);
        if (exp_q.size() > 0) check_val($sformatf("out%0d", nout), out_data, exp_q.pop_front());
        obs_q.push_back(int'(out_data));
        nout++;
      end
      if (in_valid && in_ready) idx++;
      if (abort_after > 0 && idx >= abort_after) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_after == 0) begin
      check_val("frame_done_seen", seen_done, 1);
      check_val("out_count", nout, NOUT);
      if (policy == 0) check_val("full_rate", int'(cyc <= NPIX + 4), 1);
      @(negedge clk);
      #1;
      check_val("busy_fall", busy, 0);
      check_val("done_width", done, 0);
    end
  endtask

  task automatic check_obs(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : -1, e[i]);
  endtask

  initial begin
    do_reset(3);

    for (int i = 0; i < NPIX; i++) pix[i] = i;
    run_frame(1'b1, 0, 0, 1'b0);
`ifdef DS_ROUND_EN
    check_obs("avg_ramp", 3, 5, 11, 13);
`else
    check_obs("avg_ramp", 2, 4, 10, 12);
`endif

    run_frame(1'b0, 0, 0, 1'b0);
    check_obs("dec_ramp", 0, 2, 8, 10);

    for (int i = 0; i < NPIX; i++) pix[i] = 255;
    run_frame(1'b1, 1, 0, 1'b0);
    check_obs("avg_full", 255, 255, 255, 255);

    for (int i = 0; i < NPIX; i++) pix[i] = i;
    run_frame(1'b1, 2, 0, 1'b0);

    run_frame(1'b1, 0, 6, 1'b0);
    do_reset(1);
    run_frame(1'b1, 0, 0, 1'b1);
`ifdef DS_ROUND_EN
    check_obs("after_rst", 3, 5, 11, 13);
`else
    check_obs("after_rst", 2, 4, 10, 12);
`endif

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = $urandom_range(0, 255);
      run_frame(logic'($urandom_range(0, 1)), 1, 0, f[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_downsampler.md
# image_downsampler

Parametrised streaming downsampler that reduces an IMG_W x IMG_H raster by FACTOR in both axes, per channel, in either decimate or box-average mode. Sits between the UART receive/image buffer path and the transmit path of the processor top level. It generalises the fixed single-channel downsampler with configurable geometry, channel count, run-time mode and valid/ready backpressure on both sides.

## Interface
- PIX_W, 8: bits per channel sample
- CHANNELS, 1: channels packed per pixel, channel 0 in LSBs
- IMG_W, 256: input line width in pixels; multiple of FACTOR
- IMG_H, 256: input frame height in lines; multiple of FACTOR
- FACTOR, 2: downsample factor, power of two, 2..8
- clock  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- mode  in  1  0 = decimate, 1 = box average; sampled on accepted start
- in_valid  in  1  input pixel valid
- in_data  in  CHANNELS*PIX_W  input pixel, raster order
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- out_valid  out  1  output pixel valid
- out_data  out  CHANNELS*PIX_W  downsampled pixel, raster order
- out_ready  in  1  output consumed when out_valid && out_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output is consumed

## Operation
- States: IDLE -> RUN on start; RUN -> FLUSH after the last input pixel is accepted; FLUSH -> DONE when the output register is empty or consumed; DONE -> IDLE after 1 cycle (done=1 in DONE).
- start outside IDLE ignored; mode latched only on accepted start.
- Counters: col 0..IMG_W-1, row 0..IMG_H-1; col wraps to 0 and row increments on the last pixel of a line.
- Block indices: bx = col/FACTOR, sub-column = col%FACTOR, sub-row = row%FACTOR.
- Average mode: per-channel horizontal sum over FACTOR pixels; added into line accumulator entry bx. On sub-row 0, the entry is overwritten, not added. Accumulator width ACC_W = PIX_W + 2*log2(FACTOR), which cannot overflow.
- Output emitted when sub-row = FACTOR-1 and sub-column = FACTOR-1. Value = (acc_total) >> 2*log2(FACTOR), truncated, unless DS_ROUND_EN.
- Decimate mode: output = pixel at sub-row 0, sub-column 0 of each block, held in accumulator entry bx until block completion. Emission point is the same as average mode.
- Output count per frame: (IMG_W/FACTOR)*(IMG_H/FACTOR).
- Backpressure: in_ready = (state==RUN) && (!out_valid || out_ready). No input is lost, and out_data is stable while out_valid && !out_ready.
- Reset mid-frame: all state, counters, out_valid, busy and done cleared on the next edge. Accumulator contents are don't-care, because sub-row 0 overwrites them.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- busy rises the cycle after start is accepted; in_ready can be high that same cycle.
- Latency: out_valid is asserted the cycle after the block-completing input is accepted.
- Throughput: 1 pixel/cycle with out_ready held high.
- done pulses 1 cycle after FLUSH sees the final output consumed. busy falls with done deassertion.
- Simultaneous out_ready && new block completion: the old output is consumed and the new one loaded on the same edge, with no bubble.

## Configuration
- DS_ROUND_EN defined: average mode adds 2^(2*log2(FACTOR)-1) before the shift (round half up).
- DS_ROUND_EN undefined: plain truncation. Decimate mode is unaffected either way.

## Structure
- Package ds_pkg contains:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - MODE_DECIMATE/MODE_AVERAGE constants
  - log2 helper and ACC_W function
- Sub-module ds_line_acc: IMG_W/FACTOR x CHANNELS*ACC_W register array, one write port and one combinational read port, indexed by bx.

## Test plan
Configuration for all scenarios: IMG_W=4, IMG_H=4, FACTOR=2, PIX_W=8, CHANNELS=1.
- Average mode, input 0..15 raster, out_ready=1:
  - DS_ROUND_EN undefined -> outputs 2, 4, 10, 12, then done pulse.
  - DS_ROUND_EN defined -> outputs 3, 5, 11, 13.
- Decimate mode, same input -> outputs 0, 2, 8, 10.
- All inputs 255, average mode -> four outputs of 255 (no overflow).
- out_ready low for 10 cycles at the first output -> out_valid=1 with out_data=2 held; in_ready=0; the remaining outputs arrive intact after release.
- rst_n low for 1 cycle after 6 inputs, then restart with a full frame -> outputs 2, 4, 10, 12 with no stale data. Also, start pulsed while busy -> ignored, with the output count still 4.
